// File: rtl/sys_sched_pkg.sv
// Shared types and constants for the systolic array scheduler.
// Delay-line depth helper and default geometry live here.
package sys_sched_pkg;

  localparam int SYS_DIM_DEF  = 32;
  localparam int FEAT_LEN_DEF = 128;
  localparam int PIPE_LAT_DEF = 45;
  localparam int ADDR_W_DEF   = 16;
  localparam int TILE_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // Skew across rows and columns plus the PE pipeline and output register.
  function automatic int cap_dly(input int sys_dim, input int pipe_lat);
    return 2 * sys_dim - 2 + pipe_lat + 1;
  endfunction

endpackage

// File: rtl/sched_delay_line.sv
// Enable-gated shift register; exposes the last TAPS stages.
// Stage i holds din as it was i+1 enabled steps ago.
module sched_delay_line
  import sys_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  parameter int TAPS  = DEPTH
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [WIDTH-1:0]            din,
  output logic [TAPS-1:0][WIDTH-1:0]  taps
);

  logic [DEPTH-1:0][WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        q[i] <= q[i-1];
      end
    end
  end

  assign taps = q[DEPTH-1 -: TAPS];

endmodule

// File: rtl/sys_array_sched.sv
// Systolic array scheduler: operand reads, row skew, tile capture.
// Optional SCHED_PERF_CNT_EN adds active/stall cycle counters.
module sys_array_sched
  import sys_sched_pkg::*;
#(
  parameter int SYS_DIM  = SYS_DIM_DEF,
  parameter int FEAT_LEN = FEAT_LEN_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int TILE_W   = TILE_W_DEF
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TILE_W-1:0]  num_tiles,
  input  logic               stall_in,
  output logic               busy,
  output logic               done,
  output logic               array_enable,
  output logic               feat_rd_en,
  output logic [ADDR_W-1:0]  feat_rd_addr,
  output logic               wgt_rd_en,
  output logic [ADDR_W-1:0]  wgt_rd_addr,
  output logic [SYS_DIM-1:0] row_feed_valid,
  output logic               out_capture,
  output logic [TILE_W-1:0]  out_tile_idx,
  output logic [31:0]        active_cycles,
  output logic [31:0]        stall_cycles
);

  localparam int CD = cap_dly(SYS_DIM, PIPE_LAT);
  localparam int KW = (FEAT_LEN > 1) ? $clog2(FEAT_LEN) : 1;

  state_e            state;
  logic [TILE_W-1:0] ntiles;
  logic [TILE_W-1:0] tile;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] fa;

  logic              idle;
  logic              go;
  logic              issue;
  logic              last_k;
  logic              last_tile;
  logic              fin;
  logic              cap_last;
  logic              en_n;
  logic              cap_n;
  logic [TILE_W-1:0] nt_c;
  logic [TILE_W-1:0] tile_c;
  logic [KW-1:0]     k_c;
  logic [ADDR_W-1:0] fa_c;
  logic [SYS_DIM-1:0] rfv_n;

  logic [SYS_DIM-2:0][0:0] row_q;
  logic [0:0][0:0]         cap_q;

  // Outputs are registered, so the next-cycle values are decided here
  // from the current stall_in; in IDLE the counters read as a fresh run.
  always_comb begin
    idle      = (state == IDLE);
    go        = idle && start && (num_tiles != '0);
    nt_c      = idle ? num_tiles : ntiles;
    tile_c    = idle ? '0 : tile;
    k_c       = idle ? '0 : k;
    fa_c      = idle ? '0 : fa;
    issue     = !stall_in && (go || state == STREAM);
    last_k    = (k_c == KW'(FEAT_LEN - 1));
    last_tile = (tile_c == nt_c - TILE_W'(1));
    fin       = issue && last_k && last_tile;
    cap_last  = out_capture
             && (out_tile_idx + TILE_W'(1) == ntiles);
    en_n      = issue
             || (state == DRAIN && !stall_in && !cap_last);
    cap_n     = en_n && cap_q[0][0];
    rfv_n     = en_n ? {row_q, issue} : '0;
  end

  sched_delay_line #(
    .DEPTH (SYS_DIM - 1),
    .WIDTH (1),
    .TAPS  (SYS_DIM - 1)
  ) u_row_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (en_n),
    .din  (issue),
    .taps (row_q)
  );

  sched_delay_line #(
    .DEPTH (CD),
    .WIDTH (1),
    .TAPS  (1)
  ) u_cap_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (en_n),
    .din  (issue && last_k),
    .taps (cap_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ntiles         <= '0;
      tile           <= '0;
      k              <= '0;
      fa             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      array_enable   <= 1'b0;
      feat_rd_en     <= 1'b0;
      feat_rd_addr   <= '0;
      wgt_rd_en      <= 1'b0;
      wgt_rd_addr    <= '0;
      row_feed_valid <= '0;
      out_capture    <= 1'b0;
      out_tile_idx   <= '0;
    end else begin
      done           <= 1'b0;
      array_enable   <= en_n;
      feat_rd_en     <= issue;
      wgt_rd_en      <= issue;
      row_feed_valid <= rfv_n;
      out_capture    <= cap_n;
      if (out_capture) out_tile_idx <= out_tile_idx + TILE_W'(1);
      unique case (state)
        IDLE: begin
          if (start) begin
            ntiles       <= num_tiles;
            busy         <= 1'b1;
            out_tile_idx <= '0;
            tile         <= '0;
            k            <= '0;
            fa           <= '0;
            if (num_tiles == '0) state <= DONE;
            else if (fin)        state <= DRAIN;
            else                 state <= STREAM;
          end
        end
        STREAM: if (fin) state <= DRAIN;
        DRAIN:  if (cap_last) state <= DONE;
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (issue) begin
        feat_rd_addr <= fa_c;
        wgt_rd_addr  <= ADDR_W'(k_c);
        fa           <= fa_c + ADDR_W'(1);
        k            <= last_k ? '0 : k_c + KW'(1);
        if (last_k) tile <= tile_c + TILE_W'(1);
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_cycles <= '0;
      stall_cycles  <= '0;
    end else if (idle && start) begin
      active_cycles <= '0;
      stall_cycles  <= '0;
    end else begin
      if (array_enable && active_cycles != '1)
        active_cycles <= active_cycles + 32'd1;
      if (busy && stall_in && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign active_cycles = '0;
  assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_sys_array_sched.sv
// Directed bench for sys_array_sched with a read/capture scoreboard.
// Geometry: 4x4 array, 8 features per tile, 5-cycle PE pipeline.
module tb_sys_array_sched;

  localparam int SD = 4;
  localparam int FL = 8;
  localparam int PL = 5;
  localparam int AW = 16;
  localparam int TW = 8;

  typedef struct {
    logic [AW-1:0] fa;
    logic [AW-1:0] wa;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic          stall_in;
  logic          busy;
  logic          done;
  logic          array_enable;
  logic          feat_rd_en;
  logic [AW-1:0] feat_rd_addr;
  logic          wgt_rd_en;
  logic [AW-1:0] wgt_rd_addr;
  logic [SD-1:0] row_feed_valid;
  logic          out_capture;
  logic [TW-1:0] out_tile_idx;
  logic [31:0]   active_cycles;
  logic [31:0]   stall_cycles;

  int checks   = 0;
  int failures = 0;

  rd_t           exp_rd[$];
  logic [TW-1:0] exp_cap[$];
  rd_t           e;
  logic [TW-1:0] ec;

  int   first_rd, last_rd, rd_cnt, rf3_first, rf3_last;
  int   en_cnt, bad, addr_t6;
  logic busy1;
  int   cap_t[$];
  int   done_t[$];

  always #5 clk = ~clk;

  sys_array_sched #(
    .SYS_DIM  (SD),
    .FEAT_LEN (FL),
    .PIPE_LAT (PL),
    .ADDR_W   (AW),
    .TILE_W   (TW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_tiles      (num_tiles),
    .stall_in       (stall_in),
    .busy           (busy),
    .done           (done),
    .array_enable   (array_enable),
    .feat_rd_en     (feat_rd_en),
    .feat_rd_addr   (feat_rd_addr),
    .wgt_rd_en      (wgt_rd_en),
    .wgt_rd_addr    (wgt_rd_addr),
    .row_feed_valid (row_feed_valid),
    .out_capture    (out_capture),
    .out_tile_idx   (out_tile_idx),
    .active_cycles  (active_cycles),
    .stall_cycles   (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int capq(input int i);
    return (i < cap_t.size()) ? cap_t[i] : -1;
  endfunction

  function automatic int doneq(input int i);
    return (i < done_t.size()) ? done_t[i] : -1;
  endfunction

  // Scoreboard: every read and capture must match the next queued entry.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (feat_rd_en) begin
        checks++;
        assert (exp_rd.size() != 0) else begin
          failures++;
          $error("FAIL rd_extra observed=%0d expected=none", feat_rd_addr);
        end
        if (exp_rd.size() != 0) begin
          e = exp_rd.pop_front();
          check("feat_addr", 32'(feat_rd_addr), 32'(e.fa));
          check("wgt_addr", 32'(wgt_rd_addr), 32'(e.wa));
          check("wgt_en", 32'(wgt_rd_en), 32'd1);
        end
      end
      if (out_capture) begin
        checks++;
        assert (exp_cap.size() != 0) else begin
          failures++;
          $error("FAIL cap_extra observed=%0d expected=none", out_tile_idx);
        end
        if (exp_cap.size() != 0) begin
          ec = exp_cap.pop_front();
          check("tile_idx", 32'(out_tile_idx), 32'(ec));
        end
      end
    end
  end

  task automatic run(input int nt, input int ncyc, input int st_at,
                     input int st_len, input int mid_at, input int rst_at);
    first_rd = -1; last_rd = -1; rd_cnt = 0;
    rf3_first = -1; rf3_last = -1;
    en_cnt = 0; bad = 0; addr_t6 = -1; busy1 = 1'b0;
    cap_t.delete();
    done_t.delete();
    for (int i = 0; i < nt; i++) begin
      exp_cap.push_back(TW'(i));
      for (int kk = 0; kk < FL; kk++)
        exp_rd.push_back('{fa: AW'(i * FL + kk), wa: AW'(kk)});
    end
    num_tiles = TW'(nt);
    start = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (feat_rd_en) begin
        if (first_rd < 0) first_rd = t;
        last_rd = t;
        rd_cnt++;
      end
      if (row_feed_valid[SD-1]) begin
        if (rf3_first < 0) rf3_first = t;
        rf3_last = t;
      end
      if (array_enable) en_cnt++;
      else if (row_feed_valid != '0 || feat_rd_en || wgt_rd_en) bad++;
      if (out_capture) cap_t.push_back(t);
      if (done) done_t.push_back(t);
      if (t == 1) busy1 = busy;
      if (t == 6) addr_t6 = int'(feat_rd_addr);
      stall_in = (t >= st_at && t < st_at + st_len);
      if (t == mid_at) begin
        start = 1'b1;
        num_tiles = TW'(7);
      end
      if (t == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_ctrl",
              32'({busy, done, array_enable, feat_rd_en, wgt_rd_en,
                   out_capture, row_feed_valid}), 32'd0);
        check("rst_addr",
              {feat_rd_addr, wgt_rd_addr[7:0], out_tile_idx}, 32'd0);
        exp_rd.delete();
        exp_cap.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        break;
      end
    end
    stall_in = 1'b0;
    start = 1'b0;
  endtask

  task automatic expect_one(input string tag, input int sh);
    check({tag, "_first_rd"}, first_rd, 1);
    check({tag, "_last_rd"}, last_rd, 8 + sh);
    check({tag, "_rd_cnt"}, rd_cnt, 8);
    check({tag, "_gap"}, (last_rd - first_rd + 1) - rd_cnt, sh);
    check({tag, "_rf3_first"}, rf3_first, 4);
    check({tag, "_rf3_last"}, rf3_last, 11 + sh);
    check({tag, "_en_cnt"}, en_cnt, 20);
    check({tag, "_cap_n"}, cap_t.size(), 1);
    check({tag, "_cap_t"}, capq(0), 20 + sh);
    check({tag, "_done_n"}, done_t.size(), 1);
    check({tag, "_done_t"}, doneq(0), 22 + sh);
    check({tag, "_idle_quiet"}, bad, 0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_sb_rd"}, exp_rd.size(), 0);
    check({tag, "_sb_cap"}, exp_cap.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    stall_in = 1'b0;
    num_tiles = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl",
          32'({busy, done, array_enable, feat_rd_en, wgt_rd_en,
               out_capture, row_feed_valid}), 32'd0);
    check("reset_addr",
          {feat_rd_addr, wgt_rd_addr[7:0], out_tile_idx}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run(1, 30, -1, 0, -1, -1);
    expect_one("one", 0);
`ifdef SCHED_PERF_CNT_EN
    check("one_active", active_cycles, 32'd20);
    check("one_stall", stall_cycles, 32'd0);
`else
    check("one_active", active_cycles, 32'd0);
    check("one_stall", stall_cycles, 32'd0);
`endif

    run(1, 34, 4, 3, -1, -1);
    expect_one("stall", 3);
    check("stall_hold_addr", addr_t6, 3);
`ifdef SCHED_PERF_CNT_EN
    check("stall_cnt", stall_cycles, 32'd3);
`else
    check("stall_cnt", stall_cycles, 32'd0);
`endif

    run(3, 45, -1, 0, -1, -1);
    check("three_first_rd", first_rd, 1);
    check("three_last_rd", last_rd, 24);
    check("three_rd_cnt", rd_cnt, 24);
    check("three_en_cnt", en_cnt, 36);
    check("three_cap_n", cap_t.size(), 3);
    check("three_cap0", capq(0), 20);
    check("three_cap1", capq(1), 28);
    check("three_cap2", capq(2), 36);
    check("three_done_n", done_t.size(), 1);
    check("three_done_t", doneq(0), 38);
    check("three_quiet", bad, 0);
    check("three_sb_rd", exp_rd.size(), 0);
    check("three_sb_cap", exp_cap.size(), 0);

    run(0, 8, -1, 0, -1, -1);
    check("zero_busy1", 32'(busy1), 32'd1);
    check("zero_en_cnt", en_cnt, 0);
    check("zero_rd_cnt", rd_cnt, 0);
    check("zero_done_n", done_t.size(), 1);
    check("zero_done_t", doneq(0), 2);
    check("zero_busy_end", 32'(busy), 32'd0);

    run(1, 20, -1, 0, -1, 6);
    check("rst_run_addr5", addr_t6, 5);
    run(1, 30, -1, 0, -1, -1);
    expect_one("after_rst", 0);

    run(2, 40, -1, 0, 5, -1);
    check("mid_last_rd", last_rd, 16);
    check("mid_rd_cnt", rd_cnt, 16);
    check("mid_cap_n", cap_t.size(), 2);
    check("mid_cap0", capq(0), 20);
    check("mid_cap1", capq(1), 28);
    check("mid_done_n", done_t.size(), 1);
    check("mid_done_t", doneq(0), 30);
    check("mid_sb_rd", exp_rd.size(), 0);
    check("mid_sb_cap", exp_cap.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
